// File: rtl/lz77_decoder.sv
// Streaming LZ77 decoder: accepts (offset, match_len, char_nxt) tokens and
// rebuilds the symbol stream one char per cycle from a shifting history buffer.
module lz77_decoder #(
    parameter int              SEARCH_LEN = 9,
    parameter int              OFF_W      = 4,
    parameter int              LEN_W      = 3,
    parameter int              CHAR_W     = 8,
    parameter logic [CHAR_W-1:0] END_CHAR = 8'h24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic [OFF_W-1:0]  offset,
    input  logic [LEN_W-1:0]  match_len,
    input  logic [CHAR_W-1:0] char_nxt,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    output logic              encode,
    output logic              finish
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] COPY = 2'd1;
    localparam logic [1:0] LIT  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]              state;
    logic [CHAR_W-1:0]       hist [SEARCH_LEN];
    logic [LEN_W-1:0]        cnt;
    logic [OFF_W-1:0]        off_q;
    logic [LEN_W-1:0]        len_q;
    logic [CHAR_W-1:0]       chr_q;
    logic [CHAR_W-1:0]       copy_sym;
    logic                    emit;
    logic [CHAR_W-1:0]       sym;

    // Out-of-range offsets fall through the match and read as zero.
    always_comb begin
        copy_sym = '0;
        for (int i = 0; i < SEARCH_LEN; i++) begin
            if (off_q == OFF_W'(i)) copy_sym = hist[i];
        end
    end

    always_comb begin
        emit = (state == COPY) || (state == LIT);
        sym  = (state == LIT) ? chr_q : copy_sym;
    end

    assign tok_ready = (state == IDLE);
    assign finish    = (state == DONE);
    assign encode    = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= '0;
            len_q     <= '0;
            chr_q     <= '0;
            out_valid <= 1'b0;
            out_char  <= '0;
            for (int i = 0; i < SEARCH_LEN; i++) hist[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (emit) begin
                out_valid <= 1'b1;
                out_char  <= sym;
                hist[0]   <= sym;
                for (int i = 1; i < SEARCH_LEN; i++) hist[i] <= hist[i-1];
            end
            case (state)
                IDLE: begin
                    if (tok_valid) begin
                        off_q <= offset;
                        len_q <= match_len;
                        chr_q <= char_nxt;
                        cnt   <= '0;
                        state <= (match_len != '0) ? COPY : LIT;
                    end
                end
                COPY: begin
                    cnt <= cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) state <= LIT;
                end
                LIT: begin
                    state <= (chr_q == END_CHAR) ? DONE : IDLE;
                end
                default: begin
                    // End of stream: forget history so the next stream starts clean.
                    cnt   <= '0;
                    state <= IDLE;
                    for (int i = 0; i < SEARCH_LEN; i++) hist[i] <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed table-driven bench for lz77_decoder with hand-written reset sequences.
module tb_lz77_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic [3:0] offset = '0;
    logic [2:0] match_len = '0;
    logic [7:0] char_nxt = '0;
    logic       out_valid;
    logic [7:0] out_char;
    logic       encode;
    logic       finish;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lz77_decoder dut (
        .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .offset(offset), .match_len(match_len), .char_nxt(char_nxt),
        .out_valid(out_valid), .out_char(out_char), .encode(encode), .finish(finish)
    );

    // exp[k] is the k-th decoded char of the token (copies first, literal last).
    typedef struct {
        logic [3:0]      off;
        logic [2:0]      len;
        logic [7:0]      chr;
        logic [7:0][7:0] exp;
        bit              fin;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] o, input logic [2:0] l,
                                input logic [7:0] c, input logic [63:0] e, input bit f);
        vec_t v;
        v.off = o; v.len = l; v.chr = c; v.exp = e; v.fin = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_token(input vec_t v);
        @(negedge clk);
        chk("idle_ready", 32'(tok_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);
        tok_valid = 1'b1; offset = v.off; match_len = v.len; char_nxt = v.chr;
        @(negedge clk);
        tok_valid = 1'b0;
        chk("busy_ready", 32'(tok_ready), 32'd0);
        chk("accept_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k <= int'(v.len); k++) begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_char", 32'(out_char), 32'(v.exp[k]));
            if (k == int'(v.len)) begin
                chk("finish_last", 32'(finish), 32'(v.fin));
                chk("ready_last", 32'(tok_ready), v.fin ? 32'd0 : 32'd1);
            end else begin
                chk("finish_mid", 32'(finish), 32'd0);
                chk("ready_mid", 32'(tok_ready), 32'd0);
            end
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = mk(4'd0,  3'd0, 8'h03, 64'h03, 1'b0);
        vecs[1]  = mk(4'd0,  3'd0, 8'h0A, 64'h0A, 1'b0);
        vecs[2]  = mk(4'd0,  3'd0, 8'h01, 64'h01, 1'b0);
        vecs[3]  = mk(4'd0,  3'd0, 8'h02, 64'h02, 1'b0);
        vecs[4]  = mk(4'd1,  3'd2, 8'h05, 64'h05_02_01, 1'b0);
        vecs[5]  = mk(4'd0,  3'd0, 8'h07, 64'h07, 1'b0);
        vecs[6]  = mk(4'd0,  3'd5, 8'h00, 64'h00_07_07_07_07_07, 1'b0);
        vecs[7]  = mk(4'd0,  3'd0, 8'h24, 64'h24, 1'b1);
        vecs[8]  = mk(4'd3,  3'd1, 8'h04, 64'h04_00, 1'b0);
        vecs[9]  = mk(4'd12, 3'd1, 8'h09, 64'h09_00, 1'b0);
        vecs[10] = mk(4'd2,  3'd2, 8'h06, 64'h06_00_04, 1'b0);

        // Reset held with a token presented.
        tok_valid = 1'b1; offset = 4'd0; match_len = 3'd0; char_nxt = 8'h05;
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_finish", 32'(finish), 32'd0);
            chk("rst_char", 32'(out_char), 32'd0);
            chk("rst_encode", 32'(encode), 32'd0);
        end
        tok_valid = 1'b0;
        reset = 1'b1;
        #1 chk("rel_ready", 32'(tok_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_token(vecs[i]);

        // Reset in the middle of a long copy; history holds 06 at offset 0.
        @(negedge clk);
        tok_valid = 1'b1; offset = 4'd0; match_len = 3'd7; char_nxt = 8'h01;
        @(negedge clk);
        tok_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_valid", 32'(out_valid), 32'd1);
            chk("mid_char", 32'(out_char), 32'h06);
        end
        reset = 1'b0;
        #1 chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_ready", 32'(tok_ready), 32'd1);
        @(negedge clk);
        chk("held_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_ready", 32'(tok_ready), 32'd1);
        run_token(mk(4'd0, 3'd1, 8'h02, 64'h02_00, 1'b0));

        @(negedge clk);
        chk("tail_valid", 32'(out_valid), 32'd0);
        chk("tail_finish", 32'(finish), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
